imm_operand_stage: RTL
======================

Name: imm_operand_stage

Overview:
- Registered operand-B generator for the execute stage.
- Takes instruction bits [31:7] (presented as imm[24:0]), a format select and rs2, and produces the XLEN-wide second ALU/AGU operand.
- Generalises the combinational operand mux:
  - parametrised XLEN;
  - complete RV immediate set (I, IU, S, B, U, J, Z);
  - illegal-format flag;
  - valid/ready handshake with a 2-entry skid buffer, so decode→execute runs at full throughput under back-pressure.

Parameters:
- XLEN, 32, operand width; legal values 32 or 64.
- SKID_EN, 1, 1 = 2-entry skid buffer (in_ready is registered); 0 = single register, with in_ready = out_ready | ~out_valid.

Ports:
- clock  input  1  system clock, rising edge.
- nReset  input  1  asynchronous active-low reset.
- flush  input  1  synchronous kill of all held entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept this cycle.
- use_reg  input  1  1 = pass rs2, ignore imm/imm_sel.
- imm_sel  input  3  format select (encodings below).
- imm  input  25  instruction bits [31:7]; imm[k] = instr[k+7].
- rs2  input  XLEN  register operand.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- result  output  XLEN  generated operand.
- out_illegal  output  1  reserved imm_sel used (qualified by out_valid).

Behaviour:
- Reset (nReset low, asynchronous):
  - out_valid=0, in_ready=1, result=0, out_illegal=0;
  - skid entry empty.
- Format encodings and results (S = sign-extend to XLEN, Z = zero-extend):
  - 000 I: S(imm[24:13]).
  - 001 IU: Z(imm[24:13]).
  - 010 S: S({imm[24:18], imm[4:0]}).
  - 011 U: S({imm[24:5], 12'b0}).
  - 100 B: S({imm[24], imm[0], imm[23:18], imm[4:1], 1'b0}).
  - 101 J: S({imm[24], imm[12:5], imm[13], imm[23:14], 1'b0}).
  - 110 Z: Z(imm[12:8]) (CSR zimm).
  - 111: result 0, out_illegal=1.
- use_reg=1: result=rs2, out_illegal=0, regardless of imm_sel.
- Transfers:
  - Input transfer on in_valid & in_ready.
  - Output transfer on out_valid & out_ready.
  - Latency 1 cycle: data accepted at edge N appears on result/out_valid after edge N.
- Output register update:
  - Loads when empty, or when an output transfer occurs in the same cycle.
  - Source is the skid entry if full, otherwise the input.
- Skid buffer (SKID_EN=1):
  - When the output register holds data, out_ready=0 and an input transfer occurs, the new entry goes to skid; in_ready drops the following cycle.
  - in_ready = ~skid_full (registered).
  - When skid is full and an output transfer occurs, skid moves to the output register; in_ready returns to 1 the next cycle.
- Simultaneous input and output transfer with skid empty: output register takes the new entry; skid is unchanged.
- Stored contents are never altered while out_valid & ~out_ready; result must stay stable.
- flush:
  - At the next edge, out_valid=0 and skid emptied; in_ready=1.
  - Any input presented in the flush cycle is discarded.
  - Flush has priority over all transfers.
- Reset mid-transfer: all entries are dropped asynchronously, with no partial output.
- XLEN=64: identical extension rules; U and I sign-extend to 64 bits.

Decomposition:
- Shared package (imm_pkg):
  - imm_fmt_e enum (IMM_I, IMM_IU, IMM_S, IMM_U, IMM_B, IMM_J, IMM_Z, IMM_RSV) with the encodings above;
  - constant IMM_IN_W=25.
- Sub-module imm_decode: purely combinational, parametrised by XLEN; (imm, imm_sel, use_reg, rs2) → (value, illegal).
- The stage instantiates imm_decode on the input side and registers its output; it holds the skid and handshake logic.

Test Plan:
- Reset then addi x1,x0,-1 (instr 0xFFF00093, imm=0x1FFE001, sel=000), out_ready=1 → result 0xFFFFFFFF one cycle after accept; out_illegal=0.
- Formats on consecutive cycles, full throughput, out_ready=1:
  - lui 0x12345 (sel=011) → 0x12345000.
  - beq offset -4 (sel=100) → 0xFFFFFFFC.
  - jal offset +2048 (sel=101) → 0x00000800.
  - csrrwi zimm=31 (sel=110) → 0x0000001F.
  - sel=111 → result 0, out_illegal=1.
- Back-pressure (SKID_EN=1): hold out_ready=0 and send entries A, B, C back-to-back:
  - A and B are accepted; in_ready=0 from the cycle after B; C is held upstream;
  - on release, A, B, C emerge in order with no loss or duplication.
- use_reg=1, rs2=0xDEADBEEF, sel=111 → result 0xDEADBEEF, out_illegal=0.
- Flush with both entries full → next cycle out_valid=0, in_ready=1; nothing emitted afterwards.
- XLEN=64, lui with imm[24]=1 (instr 0x80000037) → result 0xFFFFFFFF80000000. Separately, assert nReset asynchronously mid-stall → out_valid drops immediately, before the next clock edge.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the execute-stage immediate/operand-B generator.
package imm_pkg;

    localparam int IMM_IN_W = 25;

    typedef enum logic [2:0] {
        IMM_I   = 3'b000,
        IMM_IU  = 3'b001,
        IMM_S   = 3'b010,
        IMM_U   = 3'b011,
        IMM_B   = 3'b100,
        IMM_J   = 3'b101,
        IMM_Z   = 3'b110,
        IMM_RSV = 3'b111
    } imm_fmt_e;

endpackage

// File: rtl/imm_operand_stage_if.sv
// Decode-to-execute operand bus: upstream entry fields plus the downstream result.
interface imm_operand_stage_if
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic                in_valid;
    logic                in_ready;
    logic                use_reg;
    logic [2:0]          imm_sel;
    logic [IMM_IN_W-1:0] imm;
    logic [XLEN-1:0]     rs2;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     result;
    logic                out_illegal;

    // master is the decode side feeding entries and consuming results
    modport master (
        output in_valid, use_reg, imm_sel, imm, rs2, out_ready,
        input  in_ready, out_valid, result, out_illegal
    );

    modport slave (
        input  in_valid, use_reg, imm_sel, imm, rs2, out_ready,
        output in_ready, out_valid, result, out_illegal
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV immediate reassembly from instr[31:7], or rs2 pass-through.
module imm_decode
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [IMM_IN_W-1:0] imm,
    input  logic [2:0]          imm_sel,
    input  logic                use_reg,
    input  logic [XLEN-1:0]     rs2,
    output logic [XLEN-1:0]     value,
    output logic                illegal
);

    logic signed [11:0] i_imm;
    logic signed [11:0] s_imm;
    logic signed [31:0] u_imm;
    logic signed [12:0] b_imm;
    logic signed [20:0] j_imm;

    // imm[k] is instr[k+7], so instr[31] lands on imm[24]
    assign i_imm = imm[24:13];
    assign s_imm = {imm[24:18], imm[4:0]};
    assign u_imm = {imm[24:5], 12'b0};
    assign b_imm = {imm[24], imm[0], imm[23:18], imm[4:1], 1'b0};
    assign j_imm = {imm[24], imm[12:5], imm[13], imm[23:14], 1'b0};

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        if (use_reg) begin
            value = rs2;
        end else begin
            case (imm_fmt_e'(imm_sel))
                IMM_I:   value = XLEN'(i_imm);
                IMM_IU:  value = XLEN'(imm[24:13]);
                IMM_S:   value = XLEN'(s_imm);
                IMM_U:   value = XLEN'(u_imm);
                IMM_B:   value = XLEN'(b_imm);
                IMM_J:   value = XLEN'(j_imm);
                IMM_Z:   value = XLEN'(imm[12:8]);
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/imm_operand_stage.sv
// Registered operand-B stage: decodes on the input side, then an output register
// backed by an optional skid entry so decode keeps full throughput under back-pressure.
module imm_operand_stage
    import imm_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit SKID_EN = 1'b1
) (
    input  logic                 clock,
    input  logic                 nReset,
    input  logic                 flush,
    imm_operand_stage_if.slave   bus
);

    logic [XLEN-1:0] dec_value;
    logic            dec_illegal;

    logic            out_valid_q;
    logic [XLEN-1:0] out_data_q;
    logic            out_ill_q;
    logic            skid_full_q;
    logic [XLEN-1:0] skid_data_q;
    logic            skid_ill_q;

    logic            in_xfer;
    logic            out_xfer;
    logic            load_out;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .imm     (bus.imm),
        .imm_sel (bus.imm_sel),
        .use_reg (bus.use_reg),
        .rs2     (bus.rs2),
        .value   (dec_value),
        .illegal (dec_illegal)
    );

    // With the skid enabled in_ready depends only on state, cutting the
    // combinational out_ready -> in_ready path back into decode.
    generate
        if (SKID_EN) begin : g_skid_ready
            assign bus.in_ready = ~skid_full_q;
        end else begin : g_pipe_ready
            assign bus.in_ready = bus.out_ready | ~out_valid_q;
        end
    endgenerate

    assign in_xfer  = bus.in_valid & bus.in_ready;
    assign out_xfer = out_valid_q & bus.out_ready;
    assign load_out = ~out_valid_q | out_xfer;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ill_q   <= 1'b0;
            skid_full_q <= 1'b0;
            skid_data_q <= '0;
            skid_ill_q  <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else if (load_out) begin
            // The skid entry is older than anything on the input, so it drains first.
            if (skid_full_q) begin
                out_valid_q <= 1'b1;
                out_data_q  <= skid_data_q;
                out_ill_q   <= skid_ill_q;
                skid_full_q <= 1'b0;
            end else if (in_xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= dec_value;
                out_ill_q   <= dec_illegal;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_xfer && SKID_EN) begin
            skid_full_q <= 1'b1;
            skid_data_q <= dec_value;
            skid_ill_q  <= dec_illegal;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.result      = out_data_q;
    assign bus.out_illegal = out_ill_q;

endmodule
